// File: rtl/m_btb.sv
// m_btb: N-entry fully associative branch target buffer.
//
// The IF stage looks up a PC combinationally and gets a hit flag, a
// predicted direction and a predicted target. The ID stage writes one
// resolved branch per cycle. Each entry holds a valid bit, a PC tag, a
// target PC, a saturating direction counter and an LRU age. The ages
// always form a permutation of 0..ENTRIES-1, with 0 meaning most recent.
//
// Parameters:
//   ENTRIES  number of entries (power of two, >= 2)
//   ADDR_W   width of PC tag and target (word addresses)
//   CNT_W    width of the saturating direction counter (>= 1)
//
// Ports:
//   w_clk      in   clock, all state changes on posedge
//   w_rst_n    in   synchronous active-low reset
//   w_paddr    in   lookup PC
//   w_phit     out  lookup hit
//   w_ptaken   out  predicted taken (counter MSB of hit entry, 0 on miss)
//   w_ptarget  out  predicted target (0 on miss)
//   w_uen      in   update strobe
//   w_uaddr    in   PC of the resolved branch
//   w_utaken   in   actual branch outcome
//   w_utarget  in   computed branch target
//   w_flush    in   invalidate all entries
//
// Optional feature (macro BTB_STATS_EN):
//   r_ucnt      out  number of accepted updates (saturating, 32 bits)
//   r_ucorrect  out  number of updates that hit with a correct prediction

module m_btb #(
  parameter int ENTRIES = 4,
  parameter int ADDR_W  = 11,
  parameter int CNT_W   = 2
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic [ADDR_W-1:0] w_paddr,
  output logic              w_phit,
  output logic              w_ptaken,
  output logic [ADDR_W-1:0] w_ptarget,
  input  logic              w_uen,
  input  logic [ADDR_W-1:0] w_uaddr,
  input  logic              w_utaken,
  input  logic [ADDR_W-1:0] w_utarget,
  input  logic              w_flush
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]       r_ucnt,
  output logic [31:0]       r_ucorrect
`endif
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  // Weakly taken / weakly not-taken are the two values straddling the MSB.
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [IDX_W-1:0] AGE_LRU = IDX_W'(ENTRIES - 1);

  logic              valid_q  [ENTRIES];
  logic [ADDR_W-1:0] tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];
  logic [IDX_W-1:0]  age_q    [ENTRIES];

  logic             u_hit;
  logic [IDX_W-1:0] u_hit_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] lru_idx;
  logic [IDX_W-1:0] touch_idx;
  logic [IDX_W-1:0] touch_age;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] cnt_next;

  // Lookup port. Because the update path never allocates a second entry
  // for a tag already present, at most one entry can match here.
  always_comb begin
    w_phit    = 1'b0;
    w_ptaken  = 1'b0;
    w_ptarget = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == w_paddr)) begin
        w_phit    = 1'b1;
        w_ptaken  = cnt_q[i][CNT_W-1];
        w_ptarget = target_q[i];
      end
    end
  end

  // Update victim selection: matching entry first, else the lowest-index
  // invalid entry, else the entry whose age marks it least recently used.
  always_comb begin
    u_hit      = 1'b0;
    u_hit_idx  = '0;
    free_found = 1'b0;
    free_idx   = '0;
    lru_idx    = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == w_uaddr)) begin
        u_hit     = 1'b1;
        u_hit_idx = IDX_W'(i);
      end
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (age_q[i] == AGE_LRU) begin
        lru_idx = IDX_W'(i);
      end
    end
    touch_idx = u_hit ? u_hit_idx : (free_found ? free_idx : lru_idx);
    touch_age = age_q[touch_idx];
  end

  // New counter value: saturating step on a hit, weak state on allocation.
  always_comb begin
    hit_cnt  = cnt_q[u_hit_idx];
    cnt_next = w_utaken ? CNT_WT : CNT_WNT;
    if (u_hit) begin
      if (w_utaken) begin
        cnt_next = (hit_cnt == CNT_MAX) ? hit_cnt : hit_cnt + 1'b1;
      end else begin
        cnt_next = (hit_cnt == '0) ? hit_cnt : hit_cnt - 1'b1;
      end
    end
  end

  // Table state. Flush only drops valid bits so the LRU permutation stays
  // intact; a flush swallows any update in the same cycle.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
        age_q[i]    <= IDX_W'(i);
      end
    end else if (w_flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (w_uen) begin
      valid_q[touch_idx]  <= 1'b1;
      tag_q[touch_idx]    <= w_uaddr;
      target_q[touch_idx] <= w_utarget;
      cnt_q[touch_idx]    <= cnt_next;
      // Touched entry becomes age 0; only younger entries shift up by one,
      // which keeps the ages a permutation.
      for (int i = 0; i < ENTRIES; i++) begin
        if (IDX_W'(i) == touch_idx) begin
          age_q[i] <= '0;
        end else if (age_q[i] < touch_age) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef BTB_STATS_EN
  // Prediction statistics; they survive a flush and saturate at all ones.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_ucnt     <= '0;
      r_ucorrect <= '0;
    end else if (w_uen && !w_flush) begin
      if (r_ucnt != 32'hFFFF_FFFF) begin
        r_ucnt <= r_ucnt + 32'd1;
      end
      if (u_hit && (cnt_q[u_hit_idx][CNT_W-1] == w_utaken) &&
          (r_ucorrect != 32'hFFFF_FFFF)) begin
        r_ucorrect <= r_ucorrect + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/m_btb.md
Name: m_btb

Overview:
- Parametrised branch target buffer for the 5-stage pipeline. It replaces the fixed 2-entry direction predictor and 2-entry target cache with one N-entry, fully associative table.
- Each entry holds a valid bit, a branch PC tag, a target PC, a saturating direction counter and an LRU age.
- The IF stage looks up r_pc combinationally. The ID stage writes resolved branches one per cycle.

Parameters:
- ENTRIES, 4, number of table entries; power of two, minimum 2.
- ADDR_W, 11, width of PC tag and target (word addresses).
- CNT_W, 2, width of the saturating direction counter; minimum 1.

Ports:
- w_clk  input  1  clock; all state updates on posedge.
- w_rst_n  input  1  synchronous reset, active-low.
- w_paddr  input  ADDR_W  lookup PC (IF stage).
- w_phit  output  1  lookup hit (valid entry with tag == w_paddr).
- w_ptaken  output  1  predicted taken: MSB of the hit entry's counter; 0 on miss.
- w_ptarget  output  ADDR_W  target of the hit entry; 0 on miss.
- w_uen  input  1  update strobe (resolved branch, not interlocked).
- w_uaddr  input  ADDR_W  PC of the resolved branch.
- w_utaken  input  1  actual branch outcome.
- w_utarget  input  ADDR_W  computed branch target (written whether taken or not).
- w_flush  input  1  invalidate all entries.

Behaviour:
- Reset:
  - Applied when w_rst_n==0 at posedge.
  - All valid bits 0, tags 0, targets 0, counters 0.
  - Age of entry i = i.
  - Outputs w_phit/w_ptaken/w_ptarget = 0 the cycle after reset. Reset has priority over flush and update.
- Lookup:
  - Purely combinational, zero latency.
  - At most one valid entry ever matches a given tag; the implementation maintains this invariant.
  - No bypass: a same-cycle update to the looked-up address is visible only from the next cycle.
- Update hit (w_uen and a valid tag matches w_uaddr):
  - Counter saturating-increments if w_utaken, else saturating-decrements (bounds 0 and 2^CNT_W-1).
  - Target <= w_utarget. The entry becomes MRU.
- Update miss:
  - Allocate the lowest-index invalid entry if one exists; otherwise allocate the entry with age ENTRIES-1 (LRU).
  - Write valid=1, tag=w_uaddr, target=w_utarget.
  - Counter = w_utaken ? 2^(CNT_W-1) (weakly taken) : 2^(CNT_W-1)-1 (weakly not-taken).
  - The entry becomes MRU.
- LRU ages:
  - Each age is log2(ENTRIES) bits, and ages form a permutation of 0..ENTRIES-1 at all times.
  - On touching entry k with old age a: age[k] <= 0, and every entry with age < a increments. Others hold.
- Flush:
  - w_flush at posedge clears all valid bits. Ages, tags, targets and counters hold.
  - Flush wins over a simultaneous update (the update is dropped).
- Invalid entries never hit, even if tag matches.
- With CNT_W==1, weakly taken = 1 and weakly not-taken = 0.

Optional Feature:
- Macro: BTB_STATS_EN.
- When defined:
  - Adds outputs r_ucnt (32) and r_ucorrect (32), both reset to 0 and unaffected by w_flush.
  - Each accepted update (w_uen, not flushed, not in reset) increments r_ucnt.
  - r_ucorrect increments when the update hits and the pre-update counter MSB equals w_utaken. A miss never counts as correct.
  - Both counters saturate at 32'hFFFFFFFF.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then lookup 11'h010 -> w_phit=0, w_ptaken=0, w_ptarget=0.
- Update (11'h010, taken, 11'h020), then lookup 11'h010 next cycle -> hit=1, taken=1, target=11'h020. A lookup in the same cycle as the update -> hit=0.
- Four not-taken updates of 11'h010 after the taken update (counter 2->1->0->0->0) -> w_ptaken=0. One taken update -> counter 1, still 0. A second taken update -> 1.
- ENTRIES=4: allocate A,B,C,D, update A again, then allocate E -> B evicted (lookup B misses; A, C, D, E hit).
- Flush asserted together with an update of 11'h030 -> the next cycle all lookups miss, including 11'h030. Deassert w_rst_n mid-sequence -> all entries miss the next cycle.
- BTB_STATS_EN: update X taken (miss), X taken (hit, predicted 1), X not-taken (hit, predicted 1) -> r_ucnt=3, r_ucorrect=1.
